// File: rtl/pm1_pkg.sv
// pm1_pkg: shared widths, FSM state encoding and handshake helper for the
// Pollard p-1 stage 1 scheduler.
package pm1_pkg;

    localparam int DEF_PW        = 9;
    localparam int DEF_GCD_EVERY = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_POWER,
        S_ISSUE,
        S_GCD,
        S_DONE
    } state_e;

    function automatic logic hs(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/pm1_prime_power.sv
// pm1_prime_power: raises p to its largest power q = p^k <= b1, one multiply
// per cycle; done_o is high in the cycle the next multiply would exceed b1.
module pm1_prime_power
    import pm1_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [PW-1:0] p_i,
    input  logic [PW-1:0] b1_i,
    output logic          done_o,
    output logic [PW-1:0] q_o
);

    logic [PW-1:0]   p_q;
    logic [PW-1:0]   q_q;
    logic            run_q;
    logic [2*PW-1:0] prod;

    // Double-width product so the b1 comparison can never wrap.
    assign prod   = {{PW{1'b0}}, q_q} * {{PW{1'b0}}, p_q};
    assign done_o = run_q && (prod > {{PW{1'b0}}, b1_i});
    assign q_o    = q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q   <= '0;
            q_q   <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            p_q   <= p_i;
            q_q   <= p_i;
            run_q <= 1'b1;
        end else if (run_q) begin
            run_q <= !done_o;
            q_q   <= done_o ? q_q : prod[PW-1:0];
        end
    end

endmodule

// File: rtl/pm1_stage1_scheduler.sv
// pm1_stage1_scheduler: Pollard p-1 stage 1 sequencer; turns sieve primes into
// prime-power exponent issues with periodic and final gcd checks.
module pm1_stage1_scheduler
    import pm1_pkg::*;
#(
    parameter int PW        = DEF_PW,
    parameter int GCD_EVERY = DEF_GCD_EVERY
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [PW-1:0] b1_i,
    input  logic [PW-1:0] prime_i,
    input  logic          prime_valid_i,
    output logic          prime_ready_o,
    input  logic          sieve_wrap_i,
    output logic [PW-1:0] exp_data_o,
    output logic          exp_valid_o,
    input  logic          exp_ready_i,
    output logic          gcd_req_o,
    input  logic          gcd_ack_i,
    input  logic          gcd_hit_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          found_o
);

    localparam int CW = $clog2(GCD_EVERY + 1);

    state_e        state_q, state_d, end_st;
    logic [PW-1:0] b1_q, b1_d, exp_data_q, exp_data_d, pp_q;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          open_q, open_d, busy_q, busy_d, found_q, found_d;
    logic          prime_ready_q, exp_valid_q, gcd_req_q, done_q;
    logic          pp_start, pp_done, accept, wrap_cnt;

    assign cnt_inc  = cnt_q + 1'b1;
    assign wrap_cnt = (cnt_inc == CW'(GCD_EVERY));
    assign accept   = hs(prime_valid_i, prime_ready_q);
    assign end_st   = (cnt_q != '0) ? S_GCD : S_DONE;

    pm1_prime_power #(.PW(PW)) u_power (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (pp_start),
        .p_i     (prime_i),
        .b1_i    (b1_q),
        .done_o  (pp_done),
        .q_o     (pp_q)
    );

    // A start with b1<2 parks in IDLE with busy set for one cycle, then finishes.
    always_comb begin
        state_d    = state_q;
        b1_d       = b1_q;
        cnt_d      = cnt_q;
        open_d     = open_q;
        busy_d     = busy_q;
        found_d    = found_q;
        exp_data_d = exp_data_q;
        pp_start   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (busy_q) begin
                    state_d = S_DONE;
                end else if (start_i) begin
                    b1_d    = b1_i;
                    cnt_d   = '0;
                    open_d  = 1'b1;
                    busy_d  = 1'b1;
                    found_d = 1'b0;
                    state_d = (b1_i[PW-1:1] == '0) ? S_IDLE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (sieve_wrap_i || (accept && prime_i > b1_q)) begin
                    open_d  = 1'b0;
                    state_d = end_st;
                end else if (accept && prime_i[PW-1:1] != '0) begin
                    pp_start = 1'b1;
                    state_d  = S_POWER;
                end
            end
            S_POWER: begin
                exp_data_d = pp_done ? pp_q : exp_data_q;
                state_d    = pp_done ? S_ISSUE : S_POWER;
            end
            S_ISSUE: begin
                if (hs(exp_valid_q, exp_ready_i)) begin
                    cnt_d   = wrap_cnt ? '0 : cnt_inc;
                    state_d = wrap_cnt ? S_GCD : S_FETCH;
                end
            end
            S_GCD: begin
                if (gcd_ack_i) begin
                    found_d = gcd_hit_i;
                    state_d = (gcd_hit_i || !open_q) ? S_DONE : S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE) busy_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            b1_q          <= '0;
            cnt_q         <= '0;
            open_q        <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exp_data_q    <= '0;
            prime_ready_q <= 1'b0;
            exp_valid_q   <= 1'b0;
            gcd_req_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            b1_q          <= b1_d;
            cnt_q         <= cnt_d;
            open_q        <= open_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exp_data_q    <= exp_data_d;
            prime_ready_q <= (state_d == S_FETCH);
            exp_valid_q   <= (state_d == S_ISSUE);
            gcd_req_q     <= (state_d == S_GCD);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign prime_ready_o = prime_ready_q;
    assign exp_valid_o   = exp_valid_q;
    assign exp_data_o    = exp_data_q;
    assign gcd_req_o     = gcd_req_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign found_o       = found_q;

endmodule

// File: tb/tb_pm1_stage1_scheduler.sv
// tb_pm1_stage1_scheduler: directed and randomized runs of the stage 1 scheduler
// against a transaction-level model of the expected issue/gcd sequence.
module tb_pm1_stage1_scheduler;

    localparam int PW = 9;
    localparam int GE = 2;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic          prime_valid = 1'b0, sieve_wrap = 1'b0, exp_ready = 1'b0;
    logic          gcd_ack = 1'b0, gcd_hit = 1'b0;
    logic [PW-1:0] b1 = '0, prime_in = '0;
    logic          prime_ready, exp_valid, gcd_req, busy, done, found;
    logic [PW-1:0] exp_data;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int primes[$], pr[$], expv[$], obs[$];
    bit hits[$];

    pm1_stage1_scheduler #(.PW(PW), .GCD_EVERY(GE)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .b1_i          (b1),
        .prime_i       (prime_in),
        .prime_valid_i (prime_valid),
        .prime_ready_o (prime_ready),
        .sieve_wrap_i  (sieve_wrap),
        .exp_data_o    (exp_data),
        .exp_valid_o   (exp_valid),
        .exp_ready_i   (exp_ready),
        .gcd_req_o     (gcd_req),
        .gcd_ack_i     (gcd_ack),
        .gcd_hit_i     (gcd_hit),
        .busy_o        (busy),
        .done_o        (done),
        .found_o       (found)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    function automatic int max_pow(input int p, input int b, output int k);
        int q = p;
        k = 1;
        while (q * p <= b) begin
            q = q * p;
            k++;
        end
        return q;
    endfunction

    // Expected sequence of issued q values (-1 marks a gcd request); returns found.
    function automatic bit model(input int b);
        int cnt = 0, g = 0, k;
        expv.delete();
        foreach (pr[i]) begin
            if (pr[i] < 2) continue;
            if (pr[i] > b) break;
            expv.push_back(max_pow(pr[i], b, k));
            cnt++;
            if (cnt == GE) begin
                cnt = 0;
                expv.push_back(-1);
                if (hits[g]) return 1'b1;
                g++;
            end
        end
        if (cnt != 0) begin
            expv.push_back(-1);
            return hits[g];
        end
        return 1'b0;
    endfunction

    task automatic run(input int b, input int rdy_pct, input int ack_max, input int stall_q, input bit poke);
        int pi = 0, gi = 0, acc_cyc = 0, acc_p = 0, stall = 0, ack_wait = -1, t = 0, k, q;
        logic prev_ev = 1'b0, pv_v = 1'b0, pv_g = 1'b0;
        logic [PW-1:0] pv_d = '0;
        bit fnd;
        obs.delete();
        @(negedge clk);
        start = 1'b1;
        b1 = PW'(b);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        while (!done && t < 5000) begin
            chk("exclusive", $countones({prime_ready, exp_valid, gcd_req}) <= 1, 1);
            if (pv_v) chk("exp_hold", {exp_valid, exp_data}, {1'b1, pv_d});
            if (pv_g) chk("gcd_hold", gcd_req, 1);
            if (exp_valid && !prev_ev) begin
                q = max_pow(acc_p, b, k);
                chk("power_latency", cyc - acc_cyc, k);
                chk("exp_q", exp_data, q);
                if (exp_data == PW'(stall_q)) stall = 5;
            end
            sieve_wrap  = (pi >= pr.size());
            prime_valid = sieve_wrap ? 1'b1 : ($urandom_range(99) < 80);
            prime_in    = sieve_wrap ? PW'(2) : PW'(pr[pi]);
            if (prime_ready && prime_valid && !sieve_wrap) begin
                acc_p   = pr[pi];
                acc_cyc = cyc + 1;
                pi++;
            end
            exp_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (stall > 0) stall--;
            if (exp_valid && exp_ready) obs.push_back(int'(exp_data));
            gcd_ack = 1'b0;
            gcd_hit = 1'b0;
            if (gcd_req) begin
                if (ack_wait < 0) ack_wait = $urandom_range(ack_max);
                if (ack_wait == 0) begin
                    gcd_ack  = 1'b1;
                    gcd_hit  = hits[gi];
                    gi++;
                    obs.push_back(-1);
                    ack_wait = -1;
                end else begin
                    ack_wait--;
                end
            end
            if (poke) begin
                start = busy && (t % 13 == 7);
                b1    = PW'($urandom);
            end
            prev_ev = exp_valid;
            pv_v    = exp_valid && !exp_ready;
            pv_d    = exp_data;
            pv_g    = gcd_req && !gcd_ack;
            t++;
            @(negedge clk);
        end
        start = 1'b0; prime_valid = 1'b0; sieve_wrap = 1'b0; exp_ready = 1'b0; gcd_ack = 1'b0; gcd_hit = 1'b0;
        chk("run_finished", done, 1);
        fnd = model(b);
        chk("event_count", obs.size(), expv.size());
        for (int i = 0; i < obs.size() && i < expv.size(); i++) chk("event", obs[i], expv[i]);
        chk("found", found, fnd);
        chk("busy_at_done", busy, 0);
        prime_valid = 1'b1;
        prime_in = PW'(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_held", {done, found}, {1'b1, fnd});
            chk("quiet_after_done", {prime_ready, exp_valid, gcd_req}, 0);
        end
        prime_valid = 1'b0;
    endtask

    task automatic fill_hits(input int one_in);
        hits.delete();
        for (int i = 0; i < 300; i++) hits.push_back(one_in > 0 && $urandom_range(one_in - 1) == 0);
    endtask

    initial begin
        for (int n = 2; n < 512; n++) begin
            bit is_p = 1'b1;
            for (int d = 2; d * d <= n; d++) if (n % d == 0) is_p = 1'b0;
            if (is_p) primes.push_back(n);
        end
        @(negedge clk);
        chk("reset_outputs", {prime_ready, exp_valid, gcd_req, busy, done, found, exp_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // basic run ending on a prime above b1
        pr = '{2, 3, 5, 7, 11};
        fill_hits(0);
        run(10, 100, 0, 0, 1'b0);
        // factor found at the first gcd
        pr = '{2, 3, 5, 7};
        fill_hits(0);
        hits[0] = 1'b1;
        run(30, 100, 2, 0, 1'b0);
        // exp_ready withheld for 5 cycles on q=9
        pr = '{2, 3, 5, 7, 11};
        fill_hits(0);
        run(10, 100, 1, 9, 1'b0);
        // sieve wrap after 11, with 0/1 primes and stray starts mid-run
        pr = '{2, 3, 5, 1, 7, 0, 11};
        run(100, 70, 3, 0, 1'b1);
        // b1 < 2 finishes two cycles after start without any request
        @(negedge clk);
        start = 1'b1;
        b1 = PW'(1);
        prime_valid = 1'b1;
        prime_in = PW'(3);
        @(negedge clk);
        start = 1'b0;
        chk("b1lt2_busy", {busy, done, prime_ready}, 3'b100);
        @(negedge clk);
        chk("b1lt2_done", {busy, done, found}, 3'b010);
        chk("b1lt2_quiet", {prime_ready, exp_valid, gcd_req}, 0);
        prime_valid = 1'b0;
        // reset during POWER
        @(negedge clk);
        start = 1'b1;
        b1 = PW'(500);
        @(negedge clk);
        start = 1'b0;
        prime_valid = 1'b1;
        prime_in = PW'(2);
        chk("rst_fetch_ready", prime_ready, 1);
        @(negedge clk);
        prime_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_power", {prime_ready, exp_valid, busy}, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {prime_ready, exp_valid, gcd_req, busy, done, found, exp_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pr = '{2, 3, 5, 7, 11};
        fill_hits(0);
        run(10, 100, 0, 0, 1'b0);
        // randomized runs
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(100, 3);
            pr.delete();
            for (int i = 0; i < n && i < primes.size(); i++) begin
                if ($urandom_range(9) == 0) pr.push_back($urandom_range(1));
                pr.push_back(primes[i]);
            end
            fill_hits(5);
            run((r % 3 == 0) ? $urandom_range(20, 2) : $urandom_range(511, 2),
                $urandom_range(100, 30), $urandom_range(4), 0, 1'b1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
